// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and elaboration-time transition function for seq_detector_param
package seq_det_pkg;

    localparam int SEQ_DET_LEN_MIN   = 2;
    localparam int SEQ_DET_LEN_MAX   = 32;
    localparam int SEQ_DET_CNT_W_MIN = 1;
    localparam int SEQ_DET_CNT_W_MAX = 32;

    function automatic int seq_det_state_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // Next matched-prefix length after accepting in_bit in the given state.
    // A full match restarts from the longest proper border (overlap) or from 0.
    function automatic int seq_det_next_state(input logic [31:0] pattern, input int len,
                                              input int state, input logic in_bit,
                                              input bit overlap);
        int   cap;
        int   idx;
        logic sb;
        logic ok;
        if (state == len - 1 && in_bit == pattern[len-1-state] && !overlap)
            return 0;
        cap = (state + 1 < len - 1) ? state + 1 : len - 1;
        for (int k = cap; k >= 1; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                idx = state + 1 - k + j;
                sb  = (idx == state) ? in_bit : pattern[len-1-idx];
                if (sb != pattern[len-1-j])
                    ok = 1'b0;
            end
            if (ok)
                return k;
        end
        return 0;
    endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// rtl/seq_det_match_counter.sv - saturating match counter with synchronous clear priority
module seq_det_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector; SEQDET_MATCH_COUNTER_EN builds match_cnt
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8,
    localparam int                    SW          = seq_det_state_w(PATTERN_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state_out
);

    localparam logic [SW-1:0] LAST = SW'(PATTERN_LEN - 1);

    if (PATTERN_LEN < SEQ_DET_LEN_MIN || PATTERN_LEN > SEQ_DET_LEN_MAX) begin : g_bad_len
        $error("seq_detector_param: PATTERN_LEN out of range");
    end
    if (CNT_W < SEQ_DET_CNT_W_MIN || CNT_W > SEQ_DET_CNT_W_MAX) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W out of range");
    end

    // Transition table and expected-bit table are constants fixed at elaboration.
    logic [SW-1:0] next_on0 [PATTERN_LEN];
    logic [SW-1:0] next_on1 [PATTERN_LEN];
    logic          exp_bit  [PATTERN_LEN];

    for (genvar s = 0; s < PATTERN_LEN; s++) begin : g_tbl
        localparam int N0 = seq_det_next_state(32'(PATTERN), PATTERN_LEN, s, 1'b0, OVERLAP);
        localparam int N1 = seq_det_next_state(32'(PATTERN), PATTERN_LEN, s, 1'b1, OVERLAP);
        assign next_on0[s] = SW'(N0);
        assign next_on1[s] = SW'(N1);
        assign exp_bit[s]  = PATTERN[PATTERN_LEN-1-s];
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          y_q;
    logic          match;

    assign match   = in_valid && (state_q == LAST) && (x == exp_bit[state_q]);
    assign state_d = x ? next_on1[state_q] : next_on0[state_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            y_q     <= 1'b0;
        end else begin
            y_q <= match;
            if (in_valid)
                state_q <= state_d;
        end
    end

    assign y         = y_q;
    assign state_out = state_q;

`ifdef SEQDET_MATCH_COUNTER_EN
    seq_det_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (match),
        .cnt_o (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param with a history-based reference model
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b0;
    logic in_valid = 1'b0;
    logic cnt_clr = 1'b0;

    logic       y_def, y_nov, y_p2;
    logic [7:0] c_def, c_nov;
    logic [1:0] c_p2;
    logic [1:0] s_def, s_nov;
    logic [0:0] s_p2;

    always #5 clk = ~clk;

    seq_detector_param u_def (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y_def), .match_cnt(c_def), .state_out(s_def)
    );

    seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y_nov), .match_cnt(c_nov), .state_out(s_nov)
    );

    seq_detector_param #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_p2 (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y(y_p2), .match_cnt(c_p2), .state_out(s_p2)
    );

    int          n_pass = 0;
    int          n_tot  = 0;
    int          LEN  [3] = '{4, 4, 2};
    logic [31:0] PAT  [3] = '{32'b1101, 32'b1101, 32'b11};
    bit          OV   [3] = '{1'b1, 1'b0, 1'b1};
    int          CMAX [3] = '{255, 255, 3};

    bit hist [3][$];
    int exp_y   [3];
    int exp_cnt [3];
    int exp_st  [3];
    int ycnt    [3];
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit ends_with(input bit q[$], input logic [31:0] pat, input int len, input int k);
        if (q.size() < k)
            return 1'b0;
        for (int j = 0; j < k; j++)
            if (q[q.size()-k+j] != pat[len-1-j])
                return 1'b0;
        return 1'b1;
    endfunction

    // Model state is the longest pattern prefix that ends the accepted history.
    function automatic int longest_prefix(input bit q[$], input logic [31:0] pat, input int len);
        for (int k = len - 1; k >= 1; k--)
            if (ends_with(q, pat, len, k))
                return k;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i].delete();
            exp_y[i]   = 0;
            exp_cnt[i] = 0;
            exp_st[i]  = 0;
        end
    endtask

    task automatic model_update(input bit bx, input bit bv, input bit bc);
        bit m;
        for (int i = 0; i < 3; i++) begin
            m = 1'b0;
            if (bv) begin
                hist[i].push_back(bx);
                if (hist[i].size() > 40)
                    void'(hist[i].pop_front());
                m = ends_with(hist[i], PAT[i], LEN[i], LEN[i]);
                if (m && !OV[i])
                    hist[i].delete();
            end
            exp_y[i] = m ? 1 : 0;
`ifdef SEQDET_MATCH_COUNTER_EN
            if (bc)
                exp_cnt[i] = 0;
            else if (m && exp_cnt[i] < CMAX[i])
                exp_cnt[i]++;
`else
            exp_cnt[i] = 0;
`endif
            exp_st[i] = longest_prefix(hist[i], PAT[i], LEN[i]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("def_y",   int'(y_def), exp_y[0]);
            check("def_cnt", int'(c_def), exp_cnt[0]);
            check("def_st",  int'(s_def), exp_st[0]);
            check("nov_y",   int'(y_nov), exp_y[1]);
            check("nov_cnt", int'(c_nov), exp_cnt[1]);
            check("nov_st",  int'(s_nov), exp_st[1]);
            check("p2_y",    int'(y_p2),  exp_y[2]);
            check("p2_cnt",  int'(c_p2),  exp_cnt[2]);
            check("p2_st",   int'(s_p2),  exp_st[2]);
            ycnt[0] += int'(y_def);
            ycnt[1] += int'(y_nov);
            ycnt[2] += int'(y_p2);
        end
    end

    task automatic step(input bit bx, input bit bv, input bit bc);
        x        = bx;
        in_valid = bv;
        cnt_clr  = bc;
        @(posedge clk);
        model_update(bx, bv, bc);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ycnt = '{0, 0, 0};
    endtask

    task automatic settle();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit s1 [7]  = '{1, 1, 0, 1, 1, 0, 1};
        bit s2 [6]  = '{1, 1, 1, 1, 0, 1};
        int st2 [6] = '{1, 2, 2, 2, 3, 1};

        model_reset();
        #2;
        check("reset_state", int'(s_def), 0);
        check("reset_y",     int'(y_def), 0);
        check("reset_cnt",   int'(c_def), 0);
        chk_en = 1'b1;
        do_reset();

        foreach (s1[i]) step(s1[i], 1'b1, 1'b0);
        settle();
        check("t1_def_pulses", ycnt[0], 2);
        check("t1_nov_pulses", ycnt[1], 1);
        check("t1_def_state",  int'(s_def), 1);
`ifdef SEQDET_MATCH_COUNTER_EN
        check("t1_def_cnt", int'(c_def), 2);
        check("t1_nov_cnt", int'(c_nov), 1);
`else
        check("t1_def_cnt", int'(c_def), 0);
`endif

        do_reset();
        foreach (s2[i]) begin
            step(s2[i], 1'b1, 1'b0);
            check("t2_state", int'(s_def), st2[i]);
        end
        settle();
        check("t2_pulses", ycnt[0], 1);

        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i[0], 1'b0, 1'b0);
            check("t3_gap_state", int'(s_def), 3);
        end
        check("t3_gap_pulses", ycnt[0], 0);
        step(1'b1, 1'b1, 1'b0);
        settle();
        check("t3_pulses", ycnt[0], 1);

        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t4_async_state", int'(s_def), 0);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        settle();
        check("t4_no_match", ycnt[0], 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        settle();
        check("t4_one_match", ycnt[0], 1);

        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        settle();
        check("t5_p2_pulses", ycnt[2], 5);
`ifdef SEQDET_MATCH_COUNTER_EN
        check("t5_p2_sat", int'(c_p2), 3);
`else
        check("t5_p2_sat", int'(c_p2), 0);
`endif
        step(1'b1, 1'b1, 1'b1);
        check("t5_clr_y",   int'(y_p2), 1);
        check("t5_clr_cnt", int'(c_p2), 0);
        settle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
